// File: rtl/water_pkg.sv
// water_pkg: shared encodings, widths and sensor decode helpers for the pump controller.
package water_pkg;
  localparam int LEVEL_W = 4;
  localparam int SENSOR_W = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_COOL = 2'd2, S_FAULT = 2'd3} state_t;
  function automatic logic is_therm(input logic [SENSOR_W-1:0] s);
    return (s & (s + SENSOR_W'(1))) == '0;
  endfunction
  function automatic logic [LEVEL_W-1:0] therm_level(input logic [SENSOR_W-1:0] s);
    return LEVEL_W'($countones(s));
  endfunction
endpackage

// File: rtl/level_debounce.sv
// level_debounce: debounces the tank sensor bus and decodes the thermometer code into a level.
module level_debounce
  import water_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SENSOR_W-1:0] a,
  output logic [LEVEL_W-1:0]  level,
  output logic                valid,
  output logic                rdy
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [SENSOR_W-1:0] cand;
  logic [CW-1:0] cnt;
  logic accept;
  // accept on the edge where the counter steps to DEB_CYCLES-1, so a level lands DEB_CYCLES edges after a settles
  assign accept = (a == cand) && (cnt == CW'(DEB_CYCLES - 2));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand  <= '0;
      cnt   <= '0;
      level <= '0;
      valid <= 1'b1;
      rdy   <= 1'b0;
    end else begin
      cand <= a;
      cnt  <= (a != cand) ? '0 : (cnt == CW'(DEB_CYCLES - 1)) ? cnt : cnt + 1'b1;
      if (accept) begin
        rdy   <= 1'b1;
        valid <= is_therm(cand);
        level <= is_therm(cand) ? therm_level(cand) : level;
      end
    end
  end
endmodule

// File: rtl/water_pump_ctrl.sv
// water_pump_ctrl: tank fill controller with debounced level, fill progress watchdog and pump off-time.
module water_pump_ctrl
  import water_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int MIN_OFF      = 16,
  parameter int LOW_MARK     = 1,
  parameter int HIGH_MARK    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SENSOR_W-1:0] a,
  input  logic                en,
  input  logic                clr_fault,
  output logic                pump_on,
  output logic                full,
  output logic                half,
  output logic                empty,
  output logic [LEVEL_W-1:0]  level,
  output logic                fault,
  output logic [1:0]          state
);
  localparam int FW = $clog2(FILL_TIMEOUT + 1);
  localparam int OW = $clog2(MIN_OFF + 1);
  state_t state_q, state_d;
  logic valid, rdy, err, rise, timeout, cool_done;
  logic [LEVEL_W-1:0] prev_lvl;
  logic [FW-1:0] fill_cnt;
  logic [OW-1:0] off_cnt;
  level_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .level (level),
    .valid (valid),
    .rdy   (rdy)
  );
  // no decisions are taken on the reset level until the debouncer has accepted a pattern
  assign err       = rdy && !valid;
  assign rise      = level > prev_lvl;
  assign timeout   = (fill_cnt == FW'(FILL_TIMEOUT - 1)) && !rise;
  assign cool_done = off_cnt == OW'(MIN_OFF - 1);
  assign fault     = state_q == S_FAULT;
  assign state     = state_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (err) state_d = S_FAULT;
    else begin
      case (state_q)
        S_IDLE:  state_d = (en && rdy && level <= LEVEL_W'(LOW_MARK)) ? S_FILL : S_IDLE;
        S_FILL:  state_d = timeout ? S_FAULT : (level >= LEVEL_W'(HIGH_MARK) || !en) ? S_COOL : S_FILL;
        S_COOL:  state_d = cool_done ? S_IDLE : S_COOL;
        S_FAULT: state_d = (clr_fault && valid) ? S_COOL : S_FAULT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pump_on <= 1'b0;
      full    <= 1'b0;
      half    <= 1'b0;
      empty   <= 1'b0;
    end else begin
      pump_on <= state_q == S_FILL;
      full    <= rdy && level == LEVEL_W'(8);
      half    <= rdy && level >= LEVEL_W'(4) && level < LEVEL_W'(8);
      empty   <= rdy && level == '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_lvl <= '0;
      fill_cnt <= '0;
      off_cnt  <= '0;
    end else begin
      prev_lvl <= level;
      fill_cnt <= (state_q != S_FILL || rise) ? '0 : (fill_cnt == FW'(FILL_TIMEOUT)) ? fill_cnt : fill_cnt + 1'b1;
      off_cnt  <= (state_q != S_COOL) ? '0 : (off_cnt == OW'(MIN_OFF)) ? off_cnt : off_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_water_pump_ctrl.sv
// tb_water_pump_ctrl: directed scenarios for the pump controller with hand-computed expectations.
module tb_water_pump_ctrl;
  logic clk, rst_n, en, clr_fault, pump_on, full, half, empty, fault;
  logic [7:0] a;
  logic [3:0] level;
  logic [1:0] state;
  int tests, fails;
  water_pump_ctrl #(.DEB_CYCLES(4), .FILL_TIMEOUT(20), .MIN_OFF(8), .LOW_MARK(1), .HIGH_MARK(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .clr_fault(clr_fault), .pump_on(pump_on),
    .full(full), .half(half), .empty(empty), .level(level), .fault(fault), .state(state)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  task automatic test_reset;
    rst_n = 1'b0; a = 8'h00; en = 1'b1; clr_fault = 1'b0;
    #3;
    tests++;
    if ({state, pump_on, full, half, empty, level, fault} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", {state, pump_on, full, half, empty, level, fault});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_fill_start;
    repeat (3) @(negedge clk);
    tests++;
    if (state !== 2'd0 || pump_on !== 1'b0) begin
      fails++;
      $display("FAIL start_pre_idle: got state=%0d pump=%b expected state=0 pump=0", state, pump_on);
    end
    @(negedge clk);
    tests++;
    if (state !== 2'd1 || empty !== 1'b1 || level !== 4'd0) begin
      fails++;
      $display("FAIL start_fill: got state=%0d empty=%b level=%0d expected 1 1 0", state, empty, level);
    end
    @(negedge clk);
    tests++;
    if (pump_on !== 1'b1) begin
      fails++;
      $display("FAIL start_pump: got %b expected 1", pump_on);
    end
  endtask
  task automatic test_fill_track;
    logic [8:0] p;
    for (int n = 1; n <= 8; n++) begin
      p = (9'd1 << n) - 9'd1;
      a = p[7:0];
      repeat (4) @(negedge clk);
      tests++;
      if (level !== 4'(n)) begin
        fails++;
        $display("FAIL track_level_%0d: got %0d expected %0d", n, level, n);
      end
      @(negedge clk);
      if (n < 8) begin
        tests++;
        if (half !== (n >= 4) || state !== 2'd1 || full !== 1'b0) begin
          fails++;
          $display("FAIL track_half_%0d: got half=%b state=%0d full=%b expected half=%b state=1 full=0", n, half, state, full, n >= 4);
        end
        repeat (5) @(negedge clk);
      end
    end
    tests++;
    if (state !== 2'd2 || full !== 1'b1 || half !== 1'b0) begin
      fails++;
      $display("FAIL track_full: got state=%0d full=%b half=%b expected 2 1 0", state, full, half);
    end
    @(negedge clk);
    tests++;
    if (pump_on !== 1'b0) begin
      fails++;
      $display("FAIL track_pump_off: got %b expected 0", pump_on);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (state !== 2'd2) begin
      fails++;
      $display("FAIL cool_hold: got state=%0d expected 2", state);
    end
    @(negedge clk);
    tests++;
    if (state !== 2'd0) begin
      fails++;
      $display("FAIL cool_exit: got state=%0d expected 0", state);
    end
  endtask
  task automatic test_timeout;
    a = 8'h01;
    for (int i = 0; i < 12 && state !== 2'd1; i++) @(negedge clk);
    tests++;
    if (state !== 2'd1 || level !== 4'd1) begin
      fails++;
      $display("FAIL to_enter_fill: got state=%0d level=%0d expected 1 1", state, level);
    end
    a = 8'h03;
    for (int i = 0; i < 8 && level !== 4'd2; i++) @(negedge clk);
    repeat (19) @(negedge clk);
    tests++;
    if (state !== 2'd1 || fault !== 1'b0) begin
      fails++;
      $display("FAIL to_still_fill: got state=%0d fault=%b expected 1 0", state, fault);
    end
    for (int i = 0; i < 3 && state !== 2'd3; i++) @(negedge clk);
    tests++;
    if (state !== 2'd3 || fault !== 1'b1) begin
      fails++;
      $display("FAIL to_fault: got state=%0d fault=%b expected 3 1", state, fault);
    end
    @(negedge clk);
    tests++;
    if (pump_on !== 1'b0) begin
      fails++;
      $display("FAIL to_pump_off: got %b expected 0", pump_on);
    end
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    tests++;
    if (state !== 2'd2 || fault !== 1'b0) begin
      fails++;
      $display("FAIL to_clear: got state=%0d fault=%b expected 2 0", state, fault);
    end
    for (int i = 0; i < 12 && state !== 2'd0; i++) @(negedge clk);
  endtask
  task automatic test_invalid;
    a = 8'h05;
    repeat (5) @(negedge clk);
    tests++;
    if (state !== 2'd3 || fault !== 1'b1 || level !== 4'd2) begin
      fails++;
      $display("FAIL inv_fault: got state=%0d fault=%b level=%0d expected 3 1 2", state, fault, level);
    end
    clr_fault = 1'b1;
    repeat (2) @(negedge clk);
    clr_fault = 1'b0;
    tests++;
    if (state !== 2'd3) begin
      fails++;
      $display("FAIL inv_clr_blocked: got state=%0d expected 3", state);
    end
    a = 8'h03;
    repeat (4) @(negedge clk);
    tests++;
    if (state !== 2'd3) begin
      fails++;
      $display("FAIL inv_needs_clr: got state=%0d expected 3", state);
    end
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    tests++;
    if (state !== 2'd2) begin
      fails++;
      $display("FAIL inv_recover: got state=%0d expected 2", state);
    end
    for (int i = 0; i < 12 && state !== 2'd0; i++) @(negedge clk);
  endtask
  task automatic test_glitch;
    en = 1'b0;
    a = 8'h01;
    repeat (5) @(negedge clk);
    tests++;
    if (level !== 4'd1 || state !== 2'd0) begin
      fails++;
      $display("FAIL gl_setup: got level=%0d state=%0d expected 1 0", level, state);
    end
    a = 8'h03;
    repeat (2) @(negedge clk);
    a = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++;
      if (level !== 4'd1) begin
        fails++;
        $display("FAIL gl_hold_%0d: got level=%0d expected 1", i, level);
      end
    end
  endtask
  task automatic test_reset_midfill;
    en = 1'b1;
    for (int i = 0; i < 6 && state !== 2'd1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests++;
    if (state !== 2'd1 || pump_on !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: got state=%0d pump=%b expected 1 1", state, pump_on);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({state, pump_on, full, half, empty, level, fault} !== 11'd0) begin
      fails++;
      $display("FAIL mid_async_reset: got %b expected 0", {state, pump_on, full, half, empty, level, fault});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (pump_on !== 1'b0) begin
        fails++;
        $display("FAIL mid_pump_hold_%0d: got %b expected 0", i, pump_on);
      end
    end
    for (int i = 0; i < 6 && pump_on !== 1'b1; i++) @(negedge clk);
    tests++;
    if (pump_on !== 1'b1 || level !== 4'd1) begin
      fails++;
      $display("FAIL mid_restart: got pump=%b level=%0d expected 1 1", pump_on, level);
    end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill_start();
    test_fill_track();
    test_timeout();
    test_invalid();
    test_glitch();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/water_pump_ctrl.md
WATER_PUMP_CTRL -- requirements
Module: water_pump_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4; consecutive identical sensor samples required to accept a level.
REQ-002 SHALL have parameter FILL_TIMEOUT, default 1000; max cycles in FILL without level rise before fault.
REQ-003 SHALL have parameter MIN_OFF, default 16; minimum pump-off cycles between runs.
REQ-004 SHALL have parameters LOW_MARK, default 1, and HIGH_MARK, default 8; level thresholds (0..8).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port a  input  8  tank sensors; bit i = 1 means water at or above sensor i (thermometer, bit0 lowest).
REQ-008 SHALL have port en  input  1  automatic pumping enable.
REQ-009 SHALL have port clr_fault  input  1  fault acknowledge, level-sampled.
REQ-010 SHALL have port pump_on  output  1  pump motor drive.
REQ-011 SHALL have ports full, half, empty  output  1 each  tank indications.
REQ-012 SHALL have port level  output  4  debounced level 0..8.
REQ-013 SHALL have port fault  output  1  controller in FAULT.
REQ-014 SHALL have port state  output  2  current FSM state code.

Function
REQ-015 Debounce: candidate register tracks a; counter clears on any change and increments while a equals candidate; stable value updates when counter reaches DEB_CYCLES-1, i.e. DEB_CYCLES cycles after a settles.
REQ-016 Stable pattern valid only if thermometer (form 2^n-1, n=0..8); level = n; invalid pattern holds previous level and raises sensor error.
REQ-017 empty = (level==0); half = (level>=4 && level<8); full = (level==8); all outputs registered.
REQ-018 FSM states: IDLE=0, FILL=1, COOLDOWN=2, FAULT=3.
REQ-019 IDLE -> FILL when en=1 and level<=LOW_MARK.
REQ-020 FILL -> COOLDOWN when level>=HIGH_MARK or en=0.
REQ-021 FILL -> FAULT when progress timer reaches FILL_TIMEOUT; timer clears on FILL entry and on every level increase.
REQ-022 Any state -> FAULT on sensor error; priority: sensor error > timeout > HIGH_MARK > en=0.
REQ-023 COOLDOWN -> IDLE after exactly MIN_OFF cycles in COOLDOWN; off-timer clears on entry.
REQ-024 FAULT -> COOLDOWN when clr_fault=1 and current stable pattern valid; otherwise stays in FAULT.
REQ-025 pump_on = 1 only in FILL, asserted the cycle after the transition into FILL and deasserted the cycle after leaving FILL.
REQ-026 Level drop during FILL SHALL not clear the progress timer and SHALL not change state.
REQ-027 Counters saturate; no wrap-around.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, pump_on=0, fault=0, full=0, half=0, empty=0, level=0, all counters and candidate to 0, regardless of clock.
REQ-029 Reset deassertion mid-fill SHALL restart from IDLE with debounce re-acquired; pump stays off until DEB_CYCLES after release at earliest.

Structure
REQ-030 Shared package water_pkg SHALL hold state encodings, LEVEL_W=4 and SENSOR_W=8.
REQ-031 Debounce plus thermometer decode SHALL be sub-module level_debounce (outputs level, valid); FSM and timers in top.
REQ-032 Implementation SHALL be 120-400 lines RTL, synthesizable, no latches.

Verification (DEB_CYCLES=4, MIN_OFF=8, FILL_TIMEOUT=20)
REQ-033 a=8'h00 stable, en=1 -> level=0, empty=1 after 4 cycles, state FILL, pump_on=1 next cycle.
REQ-034 In FILL, step a 8'h01,8'h03..8'hFF every 10 cycles -> level tracks 1..8, half=1 at level 4..7, full=1 and COOLDOWN at 8, pump_on=0; IDLE 8 cycles later.
REQ-035 In FILL, hold a=8'h03 for 25 cycles -> FAULT after 20 cycles without rise, pump_on=0, fault=1; clr_fault=1 -> COOLDOWN.
REQ-036 a=8'h05 stable 4 cycles in IDLE -> FAULT, level holds prior value; clr_fault with a still 8'h05 -> stays FAULT.
REQ-037 a glitch 8'h01->8'h03 for 2 cycles then back -> level stays 1.
REQ-038 rst_n low mid-FILL between clock edges -> pump_on=0, state=IDLE immediately, all outputs 0.
